// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencer (flush, handler redirect, eret return) holding EPC/cause
module exc_ctrl #(
  parameter logic [31:0] HANDLER_VEC  = 32'h0000_0080,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        udfist,
  input  logic [31:0] except_addr,
  input  logic        ovf,
  input  logic [31:0] ex_pc,
  input  logic        eret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        in_handler,
  output logic        nested_drop,
  output logic [7:0]  exc_count
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FLUSH   = 2'd1;
  localparam logic [1:0] HANDLER = 2'd2;
  localparam logic [1:0] RETURN  = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_addr_q, redirect_addr_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic        in_handler_q, in_handler_d;
  logic        nested_drop_q, nested_drop_d;
  logic [7:0]  exc_count_q, exc_count_d;
  // next-state: cnt_q counts the flush cycles still to come after the current one
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    flush_d          = flush_q;
    redirect_valid_d = 1'b0;
    redirect_addr_d  = redirect_addr_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    in_handler_d     = in_handler_q;
    nested_drop_d    = nested_drop_q;
    exc_count_d      = exc_count_q;
    case (state_q)
      IDLE: if (ovf || udfist) begin
        state_d          = FLUSH;
        cnt_d            = 3'(FLUSH_CYCLES - 1);
        flush_d          = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_addr_d  = HANDLER_VEC;
        epc_d            = ovf ? ex_pc : except_addr;
        cause_d          = ovf ? 5'd12 : 5'd10;
        exc_count_d      = (exc_count_q == 8'hFF) ? exc_count_q : exc_count_q + 8'd1;
      end
      FLUSH: begin
        state_d      = (cnt_q == 3'd0) ? HANDLER : FLUSH;
        flush_d      = cnt_q != 3'd0;
        in_handler_d = cnt_q == 3'd0;
        cnt_d        = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
      end
      HANDLER: if (eret) begin
        state_d          = RETURN;
        flush_d          = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_addr_d  = epc_q;
        in_handler_d     = 1'b0;
        nested_drop_d    = 1'b0;
      end else if (udfist || ovf) begin
        nested_drop_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        flush_d = 1'b0;
      end
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      epc_q            <= '0;
      cause_q          <= '0;
      in_handler_q     <= 1'b0;
      nested_drop_q    <= 1'b0;
      exc_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      epc_q            <= epc_d;
      cause_q          <= cause_d;
      in_handler_q     <= in_handler_d;
      nested_drop_q    <= nested_drop_d;
      exc_count_q      <= exc_count_d;
    end
  end
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign in_handler     = in_handler_q;
  assign nested_drop    = nested_drop_q;
  assign exc_count      = exc_count_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl; each redirect pulse is checked against a queued expectation
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        udfist = 1'b0, ovf = 1'b0, eret = 1'b0;
  logic [31:0] except_addr = '0, ex_pc = '0;
  logic        flush, redirect_valid, in_handler, nested_drop;
  logic [31:0] redirect_addr, epc;
  logic [4:0]  cause;
  logic [7:0]  exc_count;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic [7:0]  cnt;
  } exp_t;
  exp_t q[$];

  exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .udfist(udfist), .except_addr(except_addr),
    .ovf(ovf), .ex_pc(ex_pc), .eret(eret), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .epc(epc),
    .cause(cause), .in_handler(in_handler), .nested_drop(nested_drop),
    .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  // monitor: every redirect pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && redirect_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected addr=%h epc=%h", redirect_addr, epc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({redirect_addr, flush, epc, cause, exc_count} != {e.addr, 1'b1, e.epc, e.cause, e.cnt}) begin
          errors++;
          $display("FAIL redirect got addr=%h flush=%b epc=%h cause=%0d cnt=%0d want addr=%h flush=1 epc=%h cause=%0d cnt=%0d",
                   redirect_addr, flush, epc, cause, exc_count, e.addr, e.epc, e.cause, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] p, input logic [4:0] c, input logic [7:0] n);
    exp_t e;
    e.addr = a; e.epc = p; e.cause = c; e.cnt = n;
    q.push_back(e);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_ctl"}, 64'({flush, redirect_valid, in_handler, nested_drop}), 64'd0);
    chk({n, "_data"}, {redirect_addr, epc}, 64'd0);
    chk({n, "_cnt"}, 64'({cause, exc_count}), 64'd0);
  endtask

  // one exception from IDLE through both flush cycles into HANDLER
  task automatic take_udf(input logic [31:0] a, input logic [7:0] n);
    push(32'h80, a, 5'd10, n);
    udfist = 1'b1; except_addr = a;
    tick();
    udfist = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_eret(input logic [31:0] p, input logic [4:0] c, input logic [7:0] n);
    push(p, p, c, n);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  int expc;

  initial begin
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    // basic undefined instruction
    push(32'h80, 32'h40, 5'd10, 8'd1);
    udfist = 1'b1; except_addr = 32'h40;
    tick();
    udfist = 1'b0;
    chk("flush1", 64'({flush, in_handler}), 64'b10);
    tick();
    chk("flush2", 64'({flush, redirect_valid, in_handler}), 64'b100);
    tick();
    chk("handler", 64'({flush, in_handler}), 64'b01);
    // nested overflow dropped
    ovf = 1'b1; ex_pc = 32'h90;
    tick();
    ovf = 1'b0;
    chk("nested", {24'd0, nested_drop, epc, cause, exc_count[1:0]}, {24'd0, 1'b1, 32'h40, 5'd10, 2'd1});
    push(32'h40, 32'h40, 5'd10, 8'd1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("return", 64'({flush, in_handler, nested_drop}), 64'b100);
    tick();
    chk("idle_after_ret", 64'({flush, redirect_valid, in_handler, nested_drop}), 64'd0);
    // ovf beats simultaneous udfist
    push(32'h80, 32'h40, 5'd12, 8'd2);
    udfist = 1'b1; except_addr = 32'h44; ovf = 1'b1; ex_pc = 32'h40;
    tick();
    udfist = 1'b0; ovf = 1'b0;
    tick();
    tick();
    chk("prio_handler", 64'({in_handler, cause}), 64'({1'b1, 5'd12}));
    // eret wins over simultaneous udfist
    push(32'h40, 32'h40, 5'd12, 8'd2);
    eret = 1'b1; udfist = 1'b1;
    tick();
    eret = 1'b0; udfist = 1'b0;
    chk("eret_win", 64'({nested_drop, in_handler}), 64'd0);
    tick();
    chk("eret_win_cnt", 64'({nested_drop, exc_count}), 64'({1'b0, 8'd2}));
    // eret in IDLE ignored
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("idle_eret_ctl", 64'({flush, redirect_valid, in_handler, nested_drop}), 64'd0);
    chk("idle_eret_data", {27'd0, cause, epc}, {27'd0, 5'd12, 32'h40});
    // reset during the second flush cycle
    push(32'h80, 32'h100, 5'd10, 8'd3);
    udfist = 1'b1; except_addr = 32'h100;
    tick();
    udfist = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_zero("post_rst");
    take_udf(32'h48, 8'd1);
    chk("fresh_handler", 64'({in_handler, exc_count}), 64'({1'b1, 8'd1}));
    do_eret(32'h48, 5'd10, 8'd1);
    // udfist held through FLUSH counts once
    push(32'h80, 32'h4c, 5'd10, 8'd2);
    udfist = 1'b1; except_addr = 32'h4c;
    tick();
    tick();
    tick();
    udfist = 1'b0;
    chk("held_udf", 64'({in_handler, nested_drop, exc_count}), 64'({2'b10, 8'd2}));
    do_eret(32'h4c, 5'd10, 8'd2);
    // saturation
    expc = 2;
    for (int i = 0; i < 256; i++) begin
      expc = (expc < 255) ? expc + 1 : 255;
      take_udf(32'(i * 4), 8'(expc));
      do_eret(32'(i * 4), 5'd10, 8'(expc));
    end
    chk("saturate", 64'(exc_count), 64'd255);
    tick();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
